// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/halfword/word load-store unit for a 128-byte big-endian word memory
// Sub-word stores are read-modify-write: READ captures the merged word, WRITE drives it.
module load_store_unit (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] DataAddr,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [6:0]  addr_q;
  logic [15:0] wdata_q;
  logic [31:0] word_q;
  logic        bad;

  function automatic logic [31:0] load_lane(input logic [31:0] word, input logic [1:0] sz,
                                            input logic sx, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [1:0] sz,
                                             input logic [1:0] off, input logic [15:0] d);
    logic [31:0] r;
    r = word;
    if (sz == 2'b00) begin
      case (off)
        2'd0:    r[31:24] = d[7:0];
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        default: r[7:0]   = d[7:0];
      endcase
    end else if (off[1]) begin
      r[15:0] = d;
    end else begin
      r[31:16] = d;
    end
    return r;
  endfunction

  assign bad = (size == 2'b11) ||
               (size == 2'b01 && addr[0]) ||
               (size == 2'b10 && addr[1:0] != 2'b00) ||
               (addr[31:7] != 25'd0);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      err     <= 1'b0;
      rdata   <= 32'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= 7'd0;
      wdata_q <= 16'd0;
      word_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            size_q  <= size;
            sext_q  <= sext;
            addr_q  <= addr[6:0];
            wdata_q <= wdata[15:0];
            if (bad) begin
              err   <= 1'b1;
              rdata <= 32'd0;
              state <= DONE;
            end else if (we && size == 2'b10) begin
              word_q <= wdata;
              state  <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (we_q) begin
            word_q <= merge_lane(readData, size_q, addr_q[1:0], wdata_q);
            state  <= WRITE;
          end else begin
            rdata <= load_lane(readData, size_q, sext_q, addr_q[1:0]);
            err   <= 1'b0;
            state <= DONE;
          end
        end
        WRITE: begin
          rdata <= 32'd0;
          err   <= 1'b0;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes come straight from the state register so reset drops them at once.
  assign ready     = (state == IDLE);
  assign done      = (state == DONE);
  assign MemRead   = (state == READ);
  assign MemWrite  = (state == WRITE);
  assign DataAddr  = (MemRead || MemWrite) ? {25'd0, addr_q[6:2]} : 32'd0;
  assign writeData = MemWrite ? word_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized and directed bench for load_store_unit
// Reference model tracks expected phase sequence and memory image per accepted request.
module tb_load_store_unit;
  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sext = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        ready, done, err, MemRead, MemWrite;
  logic [31:0] rdata, DataAddr, writeData, readData;

  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_idx = 5'd0;
  logic [31:0] pre_val = 32'd0;

  int passed = 0;
  int total = 0;

  typedef enum int {P_READ, P_WRITE, P_DONE} phase_t;
  phase_t      phases[$];
  logic        pend_w = 1'b0;
  logic [4:0]  cur_idx = 5'd0;
  logic [31:0] pend_word = 32'd0;
  logic        exp_err = 1'b0, exp_err_next = 1'b0;
  logic [31:0] exp_rdata = 32'd0, exp_rdata_next = 32'd0;
  bit          rknown = 1'b1, rknown_next = 1'b1;

  load_store_unit dut (
    .CLK(CLK), .Reset(Reset), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err), .rdata(rdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .DataAddr(DataAddr), .writeData(writeData),
    .readData(readData)
  );

  always #5 CLK = ~CLK;

  assign readData = mem[DataAddr[4:0]];

  always @(posedge CLK) begin
    if (MemWrite) mem[DataAddr[4:0]] <= writeData;
    else if (pre_we) mem[pre_idx] <= pre_val;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] lane_mask(input logic [1:0] s);
    return (s == 2'b00) ? 32'hFF : 32'hFFFF;
  endfunction

  function automatic int lane_shift(input logic [1:0] s, input logic [1:0] off);
    if (s == 2'b00) return 8 * (3 - int'(off));
    return (off >= 2) ? 0 : 16;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] s,
                                           input logic x, input logic [1:0] off);
    logic [31:0] m, v;
    if (s == 2'b10) return w;
    m = lane_mask(s);
    v = (w >> lane_shift(s, off)) & m;
    if (x && ((v & ((m >> 1) + 1)) != 0)) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [1:0] s,
                                            input logic [1:0] off, input logic [31:0] d);
    logic [31:0] m;
    int sh;
    m  = lane_mask(s);
    sh = lane_shift(s, off);
    return (w & ~(m << sh)) | ((d & m) << sh);
  endfunction

  always @(negedge Reset) begin
    phases.delete();
    pend_w    = 1'b0;
    exp_err   = 1'b0;
    exp_rdata = 32'd0;
    rknown    = 1'b1;
  end

  // Model: accept when idle and req high; a write lands in the image as its WRITE phase ends.
  always @(posedge CLK) begin
    if (pre_we) ref_mem[pre_idx] = pre_val;
    if (Reset) begin
      if (phases.size() == 0) begin
        if (req) begin
          logic bad;
          bad = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'd128);
          cur_idx = addr[6:2];
          pend_w  = we && !bad;
          if (bad) begin
            phases = '{P_DONE};
            exp_err_next = 1'b1; exp_rdata_next = 32'd0; rknown_next = 1'b1;
          end else if (!we) begin
            phases = '{P_READ, P_DONE};
            exp_err_next = 1'b0; rknown_next = 1'b1;
            exp_rdata_next = ref_load(ref_mem[cur_idx], size, sext, addr[1:0]);
          end else begin
            exp_err_next = 1'b0; rknown_next = 1'b0;
            if (size == 2'b10) begin
              phases = '{P_WRITE, P_DONE};
              pend_word = wdata;
            end else begin
              phases = '{P_READ, P_WRITE, P_DONE};
              pend_word = ref_merge(ref_mem[cur_idx], size, addr[1:0], wdata);
            end
          end
        end
      end else begin
        if (phases[0] == P_WRITE && pend_w) ref_mem[cur_idx] = pend_word;
        phases.delete(0);
      end
    end
  end

  always @(negedge CLK) begin
    if (Reset) begin
      if (phases.size() == 0) begin
        check("idle_ready", ready, 1'b1);
        check("idle_done", done, 1'b0);
        check("idle_memrd", MemRead, 1'b0);
        check("idle_memwr", MemWrite, 1'b0);
        check("idle_daddr", DataAddr, 32'd0);
        check("idle_wdata", writeData, 32'd0);
      end else begin
        check("busy_ready", ready, 1'b0);
        check("memrd", MemRead, phases[0] == P_READ);
        check("memwr", MemWrite, phases[0] == P_WRITE);
        check("done", done, phases[0] == P_DONE);
        check("daddr", DataAddr, (phases[0] == P_DONE) ? 32'd0 : {27'd0, cur_idx});
        check("wdata_out", writeData, (phases[0] == P_WRITE) ? pend_word : 32'd0);
        if (phases[0] == P_DONE) begin
          exp_err = exp_err_next; exp_rdata = exp_rdata_next; rknown = rknown_next;
        end
      end
      check("err", err, exp_err);
      if (rknown) check("rdata", rdata, exp_rdata);
    end
  end

  task automatic set_word(input int i, input logic [31:0] v);
    pre_we = 1'b1; pre_idx = i[4:0]; pre_val = v;
    @(negedge CLK);
    pre_we = 1'b0;
  endtask

  task automatic mem_compare(input string name);
    for (int i = 0; i < 32; i++) check(name, mem[i], ref_mem[i]);
  endtask

  task automatic txn(input logic w, input logic [1:0] s, input logic x, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output logic e,
                     output int lat, output int rc, output int wc, output logic [31:0] wd,
                     output logic [31:0] da);
    int n;
    n = 0; rc = 0; wc = 0; wd = 0; da = 0; lat = 0; rd = 0; e = 0;
    while (!ready && n < 20) begin @(negedge CLK); n++; end
    if (!ready) begin
      check("txn_ready_timeout", ready, 1'b1);
      return;
    end
    req = 1'b1; we = w; size = s; sext = x; addr = a; wdata = d;
    @(posedge CLK);
    @(negedge CLK);
    req = 1'b0;
    lat = 1; n = 0;
    while (n < 10) begin
      if (MemRead) rc++;
      if (MemWrite) begin wc++; wd = writeData; da = DataAddr; end
      if (done) break;
      @(negedge CLK);
      lat++; n++;
    end
    check("txn_done_seen", done, 1'b1);
    rd = rdata; e = err;
  endtask

  initial begin
    logic [31:0] rd, wd, da;
    logic        e;
    int          lat, rc, wc;

    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_memrd", MemRead, 1'b0);
    check("rst_memwr", MemWrite, 1'b0);
    check("rst_daddr", DataAddr, 32'd0);
    check("rst_wdata", writeData, 32'd0);
    @(negedge CLK);
    for (int i = 0; i < 32; i++) set_word(i, $urandom);
    Reset = 1'b1;
    @(negedge CLK);

    set_word(2, 32'h80FF7F01);
    txn(1'b0, 2'b00, 1'b1, 32'h08, 32'h0, rd, e, lat, rc, wc, wd, da);
    check("lb_sext_val", rd, 32'hFFFFFF80);
    check("lb_sext_lat", lat, 2);
    txn(1'b0, 2'b00, 1'b0, 32'h08, 32'h0, rd, e, lat, rc, wc, wd, da);
    check("lb_zext_val", rd, 32'h00000080);

    set_word(1, 32'h11223344);
    txn(1'b1, 2'b00, 1'b0, 32'h06, 32'h000000AB, rd, e, lat, rc, wc, wd, da);
    check("sb_lat", lat, 3);
    check("sb_read_cycles", rc, 1);
    check("sb_write_cycles", wc, 1);
    check("sb_wdata", wd, 32'h1122AB44);
    check("sb_daddr", da, 32'd1);
    @(negedge CLK);
    check("sb_mem", mem[1], 32'h1122AB44);

    set_word(1, 32'h11223344);
    txn(1'b1, 2'b01, 1'b0, 32'h04, 32'h0000BEEF, rd, e, lat, rc, wc, wd, da);
    @(negedge CLK);
    check("sh_mem", mem[1], 32'hBEEF3344);
    txn(1'b0, 2'b01, 1'b1, 32'h06, 32'h0, rd, e, lat, rc, wc, wd, da);
    check("lh_val", rd, 32'h00003344);

    txn(1'b1, 2'b10, 1'b0, 32'h0C, 32'hCAFEF00D, rd, e, lat, rc, wc, wd, da);
    check("sw_lat", lat, 2);
    check("sw_read_cycles", rc, 0);

    txn(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, rd, e, lat, rc, wc, wd, da);
    check("lw_misalign_err", e, 1'b1);
    check("lw_misalign_lat", lat, 1);
    check("lw_misalign_rdata", rd, 32'd0);
    check("lw_misalign_strobes", rc + wc, 0);
    txn(1'b1, 2'b10, 1'b0, 32'h80, 32'h12345678, rd, e, lat, rc, wc, wd, da);
    check("sw_range_err", e, 1'b1);
    check("sw_range_lat", lat, 1);
    check("sw_range_strobes", rc + wc, 0);
    @(negedge CLK);
    mem_compare("mem_after_err");

    // Abort a byte store during its READ cycle.
    while (!ready) @(negedge CLK);
    req = 1'b1; we = 1'b1; size = 2'b00; sext = 1'b0; addr = 32'h06; wdata = 32'h000000CD;
    @(posedge CLK);
    @(negedge CLK);
    req = 1'b0;
    check("abort_in_read", MemRead, 1'b1);
    Reset = 1'b0;
    #1;
    check("abort_ready", ready, 1'b1);
    check("abort_memrd", MemRead, 1'b0);
    check("abort_memwr", MemWrite, 1'b0);
    check("abort_daddr", DataAddr, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    repeat (2) begin
      @(negedge CLK);
      check("abort_no_done", done, 1'b0);
      check("abort_no_write", MemWrite, 1'b0);
    end
    Reset = 1'b1;
    mem_compare("mem_after_abort");
    txn(1'b0, 2'b00, 1'b0, 32'h06, 32'h0, rd, e, lat, rc, wc, wd, da);
    check("post_rst_lat", lat, 2);
    check("post_rst_val", rd, 32'h00000033);

    for (int c = 0; c < 3000; c++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      @(negedge CLK);
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 19) == 0) a = $urandom;
      req = 1'b1; we = 1'($urandom); size = sz; sext = 1'($urandom);
      addr = a; wdata = $urandom;
    end
    @(negedge CLK);
    req = 1'b0;
    repeat (5) @(negedge CLK);
    mem_compare("mem_final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port: CLK  in  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: Reset  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: req  in  1  access request from the CPU; sampled only when ready=1.
REQ-004 SHALL have port: we  in  1  1=store, 0=load.
REQ-005 SHALL have port: size  in  2  access size: 00=byte, 01=halfword, 10=word; 11 is illegal.
REQ-006 SHALL have port: sext  in  1  1=sign-extend sub-word load, 0=zero-extend.
REQ-007 SHALL have port: addr  in  32  byte address.
REQ-008 SHALL have port: wdata  in  32  store data, right-justified for sub-word stores.
REQ-009 SHALL have ports: ready  out  1  idle and able to accept; done  out  1  one-cycle completion pulse; err  out  1  valid with done; rdata  out  32  load result, valid with done.
REQ-010 SHALL have ports to the data memory: MemRead  out  1; MemWrite  out  1; DataAddr  out  32  word index; writeData  out  32; readData  in  32  combinational read, big-endian (byte offset 0 = bits 31:24).

Function
REQ-011 SHALL implement the states IDLE, READ, WRITE and DONE; ready SHALL be 1 only in IDLE.
REQ-012 SHALL latch we, size, sext, addr and wdata when req=1 in IDLE; req SHALL be ignored in all other states.
REQ-013 SHALL detect an error on acceptance when size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0, or addr[31:7]!=0 (128-byte memory).
REQ-014 On an error SHALL go IDLE->DONE, with err=1 and rdata=0 in DONE, and SHALL assert neither MemRead nor MemWrite.
REQ-015 For a load SHALL go IDLE->READ->DONE, with MemRead=1 in READ and readData captured at the end of READ.
REQ-016 For a word store SHALL go IDLE->WRITE->DONE, with MemWrite=1 and writeData=wdata in WRITE.
REQ-017 For a byte or halfword store SHALL go IDLE->READ->WRITE->DONE: capture the word in READ, then in WRITE drive the captured word with only the addressed lane replaced.
REQ-018 SHALL map lanes big-endian: byte offset k occupies bits [31-8k:24-8k]; halfword offset 0 occupies [31:16] and offset 2 occupies [15:0].
REQ-019 SHALL return a load result from the selected lane, right-justified and extended per sext; a word load SHALL be returned unmodified.
REQ-020 SHALL drive DataAddr = {25'b0, addr[6:2]} from the latched address whenever MemRead or MemWrite is 1, and 0 otherwise.
REQ-021 SHALL decode MemRead and MemWrite from the registered state only, never both 1, and 0 in IDLE and DONE.
REQ-022 SHALL assert done=1 for exactly the single DONE cycle, then return to IDLE.
REQ-023 SHALL hold rdata and err until the next DONE and SHALL not pulse done again without a new accepted req.
REQ-024 Latency from the req-accepting edge to done SHALL be: load 2 cycles, word store 2, sub-word store 3, error 1.

Reset
REQ-025 While Reset=0 SHALL force state=IDLE, ready=1, done=0, err=0, rdata=0, MemRead=0, MemWrite=0, DataAddr=0, writeData=0, asynchronously.
REQ-026 Reset asserted mid-operation SHALL abandon the access with no done pulse; MemWrite SHALL drop immediately.
REQ-027 After Reset deasserts, the first req SHALL be accepted on the next rising edge.

Verification
REQ-028 Memory word 2=0x80FF7F01; byte load addr 0x08 with sext=1 -> rdata=0xFFFFFF80, done 2 cycles after accept; with sext=0 -> 0x00000080.
REQ-029 Word 1=0x11223344; byte store wdata=0x000000AB to addr 0x06 -> MemRead for one cycle, then MemWrite writeData=0x1122AB44 with DataAddr=1; done 3 cycles after accept.
REQ-030 Word 1=0x11223344; halfword store wdata=0x0000BEEF to addr 0x04 -> word 1 becomes 0xBEEF3344; halfword load addr 0x06 with sext=1 -> rdata=0x00003344.
REQ-031 Word load addr 0x02; then word store addr 0x80 -> each gives done with err=1 one cycle after accept; MemRead and MemWrite stay 0 and memory is unchanged.
REQ-032 Reset pulled low during READ of a byte store -> outputs at their reset values at once, no MemWrite, no done, memory unchanged, and the next req is accepted normally.
REQ-033 req held high continuously -> exactly one access per IDLE visit, with ready=0 in every non-IDLE cycle.
